// File: rtl/imem_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader_pkg
// Description : Shared definitions for the instruction-memory boot loader.
//               Holds the loader FSM state encoding, the err_code values,
//               the frame header length and a small state-class helper.
//               Optional feature macro: BOOT_CHECKSUM_EN adds the CSUM state
//               and the checksum error code.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
`ifdef BOOT_CHECKSUM_EN
        ST_CSUM   = 3'd4,
`endif
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } boot_state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_BAD_COUNT = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd2;
`ifdef BOOT_CHECKSUM_EN
    localparam logic [1:0] ERR_CHECKSUM  = 2'd3;
`endif

    // Header is a big-endian 16-bit word count.
    localparam int HDR_BYTES = 2;

    // True in every state that is waiting on the byte stream.
    function automatic logic is_loading(input boot_state_t s);
        logic r;
        r = 1'b0;
        case (s)
            ST_HDR_HI, ST_HDR_LO, ST_DATA: r = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM:                       r = 1'b1;
`endif
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_boot_loader_idle_timer.sv
`default_nettype none
// ============================================================================
// Module      : boot_idle_timer
// Description : Idle counter for the boot loader. Counts cycles since the
//               last clear and raises expired once TIMEOUT_CYCLES is reached
//               (the count saturates there). TIMEOUT_CYCLES == 0 builds a
//               constant-0 timer.
// Ports       : clk, reset (async, active-high), clear (restart from 0),
//               expired (terminal count reached)
// Revision    : 1.0 - initial release
// ============================================================================
module boot_idle_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset, clear};
            assign expired       = 1'b0;
        end else begin : g_enabled
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES);

            logic [CW-1:0] count;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (count != TERMINAL) begin
                    count <= count + 1'b1;
                end
            end

            assign expired = (count == TERMINAL);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Receives a framed program image as a valid/ready byte stream
//               (count_hi, count_lo, then count words MSB first), packs it
//               into 32-bit words and writes them through the core's
//               instruction-memory init port while holding the core frozen.
//               Releases init_mode on success; on error keeps the core held
//               and reports err_code (1 bad count, 2 timeout, 3 checksum).
// Macro       : BOOT_CHECKSUM_EN - expect a trailing XOR checksum byte.
// Ports       : clk, reset (async, active-high), start,
//               rx_data/rx_valid/rx_ready  byte stream in,
//               init_mode/write_enable/init_address/init_instruction  to core,
//               busy/done/error/err_code/words_loaded  status
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int MAX_WORDS      = 4096,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              init_mode,
    output logic              write_enable,
    output logic [ADDR_W-1:0] init_address,
    output logic [31:0]       init_instruction,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    boot_state_t state;
    logic [7:0]  count_hi;
    logic [15:0] word_count;
    logic [1:0]  byte_idx;
    logic [23:0] shift;
    // Set once the last data byte is in: the remaining DATA cycle is the
    // final write strobe, during which no further byte may be taken.
    logic        data_done;

    logic        accept;
    logic        expired;
    logic        timer_clear;
    logic [15:0] hdr_count;
    logic [16:0] next_words;

    assign rx_ready    = is_loading(state) && !data_done;
    assign accept      = rx_valid && rx_ready;
    assign hdr_count   = {count_hi, rx_data};
    assign next_words  = 17'(words_loaded) + 17'd1;
    // Outside the loading states the timer is parked at 0, which also covers
    // the clear on an accepted start.
    assign timer_clear = accept || !is_loading(state);

    boot_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .expired(expired)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (start && !is_loading(state)) begin
            csum <= '0;
        end else if (accept && state != ST_CSUM) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            count_hi         <= '0;
            word_count       <= '0;
            byte_idx         <= '0;
            shift            <= '0;
            data_done        <= 1'b0;
            init_mode        <= 1'b0;
            write_enable     <= 1'b0;
            init_address     <= '0;
            init_instruction <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            err_code         <= ERR_NONE;
            words_loaded     <= '0;
        end else begin
            write_enable <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state        <= ST_HDR_HI;
                        init_mode    <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        err_code     <= ERR_NONE;
                        words_loaded <= '0;
                        byte_idx     <= '0;
                        data_done    <= 1'b0;
                    end
                end
                ST_HDR_HI: begin
                    if (accept) begin
                        count_hi <= rx_data;
                        state    <= ST_HDR_LO;
                    end else if (expired) begin
                        state    <= ST_ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end
                ST_HDR_LO: begin
                    if (accept) begin
                        if (hdr_count == 16'd0 || 32'(hdr_count) > 32'(MAX_WORDS)) begin
                            state    <= ST_ERR;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_BAD_COUNT;
                        end else begin
                            word_count <= hdr_count;
                            byte_idx   <= '0;
                            state      <= ST_DATA;
                        end
                    end else if (expired) begin
                        state    <= ST_ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end
                ST_DATA: begin
                    if (data_done) begin
                        // Final strobe cycle is in progress; move on after it.
                        data_done <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                        state     <= ST_CSUM;
`else
                        state     <= ST_DONE;
                        init_mode <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
`endif
                    end else if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            write_enable     <= 1'b1;
                            init_address     <= words_loaded[ADDR_W-1:0];
                            init_instruction <= {shift, rx_data};
                            words_loaded     <= words_loaded + 1'b1;
                            if (next_words == 17'(word_count)) begin
                                data_done <= 1'b1;
                            end
                        end else begin
                            shift <= {shift[15:0], rx_data};
                        end
                    end else if (expired) begin
                        state    <= ST_ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                ST_CSUM: begin
                    if (accept) begin
                        if (rx_data == csum) begin
                            state     <= ST_DONE;
                            init_mode <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state    <= ST_ERR;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_CHECKSUM;
                        end
                    end else if (expired) begin
                        state    <= ST_ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Self-checking bench for imem_boot_loader. Frames are built
//               from a list of expected words; the expected write sequence
//               is simply word i at address i. Honours BOOT_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int ADDR_W         = 12;
    localparam int MAX_WORDS      = 8;
    localparam int TIMEOUT_CYCLES = 16;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              start    = 1'b0;
    logic [7:0]        rx_data  = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              init_mode;
    logic              write_enable;
    logic [ADDR_W-1:0] init_address;
    logic [31:0]       init_instruction;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   words_loaded;

    imem_boot_loader #(
        .ADDR_W        (ADDR_W),
        .MAX_WORDS     (MAX_WORDS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .init_mode       (init_mode),
        .write_enable    (write_enable),
        .init_address    (init_address),
        .init_instruction(init_instruction),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .err_code        (err_code),
        .words_loaded    (words_loaded)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0]        byte_q[$];
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    int                we_cyc_q[$];
    int                acc_cyc_q[$];

    // Observer: samples 2 time units after each falling edge.
    always @(negedge clk) begin
        #2;
        cyc++;
        if (write_enable === 1'b1) begin
            wa_q.push_back(init_address);
            wd_q.push_back(init_instruction);
            we_cyc_q.push_back(cyc);
        end
        if (rx_valid && rx_ready === 1'b1) acc_cyc_q.push_back(cyc);
    end

    function automatic logic [64:0] all_outputs();
        return {rx_ready, init_mode, write_enable, init_address, init_instruction,
                busy, done, error, err_code, words_loaded};
    endfunction

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        we_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic fill_random(input int cnt);
        exp_q.delete();
        for (int i = 0; i < cnt; i++) exp_q.push_back($urandom);
    endtask

    // Frame = big-endian count, words MSB first, optional XOR of all bytes.
    task automatic build_frame(input int cnt);
        logic [7:0] x;
        byte_q.delete();
        byte_q.push_back(cnt[15:8]);
        byte_q.push_back(cnt[7:0]);
        for (int i = 0; i < cnt; i++) begin
            for (int b = 3; b >= 0; b--) byte_q.push_back(exp_q[i][b*8 +: 8]);
        end
`ifdef BOOT_CHECKSUM_EN
        x = 8'h00;
        foreach (byte_q[i]) x ^= byte_q[i];
        byte_q.push_back(x);
`else
        x = 8'h00;
        if (x != 8'h00) $display("unexpected");
`endif
    endtask

    task automatic drive_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_byte: rx_ready=%b after %0d cycles, required 1", rx_ready, n);
        end
        @(negedge clk);
    endtask

    task automatic send_bytes(input int max_gap);
        int gap;
        foreach (byte_q[i]) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (gap > 0) begin
                rx_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            send_byte(byte_q[i]);
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_flag(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1 && error !== 1'b1) begin
            errors++;
            $display("FAIL %s wait: done=%b error=%b after %0d cycles, required one set", name, done, error, n);
        end
        #3;
    endtask

    task automatic check_load(input string name, input int cnt);
        wait_flag(name);
        checks++;
        if ({done, error, init_mode, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL %s flags: done/error/init_mode/busy=%b, required 1000", name,
                     {done, error, init_mode, busy});
        end
        checks++;
        if (words_loaded !== (ADDR_W+1)'(cnt)) begin
            errors++;
            $display("FAIL %s words_loaded: got %0d, required %0d", name, words_loaded, cnt);
        end
        checks++;
        if (wa_q.size() != cnt) begin
            errors++;
            $display("FAIL %s write count: got %0d, required %0d", name, wa_q.size(), cnt);
        end else begin
            for (int i = 0; i < cnt; i++) begin
                checks++;
                if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s write %0d: got addr %h data %h, required addr %h data %h",
                             name, i, wa_q[i], wd_q[i], ADDR_W'(i), exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %h, required 0", all_outputs());
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL idle outputs: got %h, required 0", all_outputs());
        end
    endtask

    task automatic test_basic();
        clear_mon();
        exp_q.delete();
        exp_q.push_back(32'h20080005);
        exp_q.push_back(32'h0000000C);
        build_frame(2);
        drive_start();
        send_bytes(0);
        check_load("basic", 2);
    endtask

    task automatic test_bad_count();
        int bad[3];
        bad[0] = 0;
        bad[1] = MAX_WORDS + 1;
        bad[2] = 16'hFFFF;
        foreach (bad[k]) begin
            clear_mon();
            byte_q.delete();
            byte_q.push_back(bad[k][15:8]);
            byte_q.push_back(bad[k][7:0]);
            drive_start();
            send_bytes(0);
            wait_flag("bad_count");
            repeat (3) @(negedge clk);
            checks++;
            if ({error, err_code, init_mode, busy, done, rx_ready} !== 7'b1_01_1000) begin
                errors++;
                $display("FAIL bad_count %0d: error/err_code/init_mode/busy/done/rx_ready=%b, required 1011000",
                         bad[k], {error, err_code, init_mode, busy, done, rx_ready});
            end
            checks++;
            if (wa_q.size() != 0) begin
                errors++;
                $display("FAIL bad_count %0d writes: got %0d, required 0", bad[k], wa_q.size());
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        clear_mon();
        byte_q.delete();
        byte_q.push_back(8'h00);
        byte_q.push_back(8'h01);
        byte_q.push_back(8'hAA);
        byte_q.push_back(8'hBB);
        drive_start();
        send_bytes(0);
        n = 0;
        while (error !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < TIMEOUT_CYCLES || n > TIMEOUT_CYCLES + 1) begin
            errors++;
            $display("FAIL timeout latency: got %0d idle cycles, required %0d..%0d", n,
                     TIMEOUT_CYCLES, TIMEOUT_CYCLES + 1);
        end
        checks++;
        if ({err_code, init_mode, busy, done} !== 5'b10_100) begin
            errors++;
            $display("FAIL timeout flags: err_code/init_mode/busy/done=%b, required 10100",
                     {err_code, init_mode, busy, done});
        end
        checks++;
        if (wa_q.size() != 0 || words_loaded !== '0) begin
            errors++;
            $display("FAIL timeout writes: got %0d writes words_loaded %0d, required 0", wa_q.size(), words_loaded);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        fill_random(2);
        build_frame(2);
        drive_start();
        send_bytes(0);
        check_load("back_to_back", 2);
        checks++;
        if (acc_cyc_q.size() < 10 || we_cyc_q.size() != 2) begin
            errors++;
            $display("FAIL b2b sizes: got %0d accepts %0d strobes, required >=10 and 2",
                     acc_cyc_q.size(), we_cyc_q.size());
        end else begin
            checks++;
            if (we_cyc_q[0] != acc_cyc_q[5] + 1) begin
                errors++;
                $display("FAIL b2b strobe: got cycle %0d, required %0d", we_cyc_q[0], acc_cyc_q[5] + 1);
            end
            checks++;
            if (acc_cyc_q[6] != we_cyc_q[0]) begin
                errors++;
                $display("FAIL b2b fifth byte: got cycle %0d, required %0d", acc_cyc_q[6], we_cyc_q[0]);
            end
            checks++;
            if (acc_cyc_q[9] - acc_cyc_q[0] != 9) begin
                errors++;
                $display("FAIL b2b stream: got span %0d, required 9", acc_cyc_q[9] - acc_cyc_q[0]);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] full[$];
        clear_mon();
        fill_random(1);
        build_frame(1);
        full   = byte_q;
        byte_q = full[0:1];
        drive_start();
        send_bytes(0);
        drive_start();
        byte_q = full[2:$];
        send_bytes(0);
        check_load("start_ignored", 1);
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] full[$];
        clear_mon();
        fill_random(3);
        build_frame(3);
        full   = byte_q;
        byte_q = full[0:7];
        drive_start();
        send_bytes(0);
        checks++;
        if (busy !== 1'b1 || words_loaded !== (ADDR_W+1)'(1)) begin
            errors++;
            $display("FAIL mid_load state: busy=%b words_loaded=%0d, required 1 and 1", busy, words_loaded);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL async reset: got %h, required 0", all_outputs());
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_mon();
        fill_random(4);
        build_frame(4);
        drive_start();
        send_bytes(0);
        check_load("after_reset", 4);
    endtask

    task automatic test_random();
        int cnt;
        for (int f = 0; f < 6; f++) begin
            clear_mon();
            cnt = (f == 0) ? MAX_WORDS : int'($urandom_range(1, MAX_WORDS));
            fill_random(cnt);
            build_frame(cnt);
            drive_start();
            send_bytes(3);
            check_load("random", cnt);
        end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        // Good case: bench-computed XOR of 00 02 20 08 00 05 00 00 00 0C (0x23).
        test_basic();
        clear_mon();
        build_frame(2);
        byte_q[byte_q.size() - 1] = 8'h0E;
        drive_start();
        send_bytes(0);
        wait_flag("checksum_bad");
        checks++;
        if ({error, err_code, init_mode, done} !== 5'b1_11_10) begin
            errors++;
            $display("FAIL checksum_bad: error/err_code/init_mode/done=%b, required 11110",
                     {error, err_code, init_mode, done});
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_bad_count();
        test_timeout();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_load();
        test_random();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
